// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus of the FIFO arbiter: two requester handshakes plus the FIFO write port.
// Valid/ready: an item transfers on the Clk edge where Valid && Ready; Ready is only offered in IDLE.
interface fifo_wr_arbiter_if #(
    parameter int Data_width = 8
);
    logic                    Req0_Valid;
    logic [Data_width-1:0]   Req0_Data;
    logic                    Req0_Ready;
    logic                    Req1_Valid;
    logic [2*Data_width-1:0] Req1_Data;
    logic                    Req1_Ready;
    logic                    Wfull;
    logic                    Winc;
    logic [Data_width-1:0]   Wrdata;

    modport master (
        output Req0_Valid, Req0_Data, Req1_Valid, Req1_Data, Wfull,
        input  Req0_Ready, Req1_Ready, Winc, Wrdata
    );

    modport slave (
        input  Req0_Valid, Req0_Data, Req1_Valid, Req1_Data, Wfull,
        output Req0_Ready, Req1_Ready, Winc, Wrdata
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port between a byte requester and a 2-byte word requester.
// Words are written low byte first as an atomic pair; runs in the FIFO write-clock domain.
module fifo_wr_arbiter #(
    parameter int Data_width  = 8,
    parameter int Count_width = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Prio_mode,
    fifo_wr_arbiter_if.slave       bus,
    output logic                   Busy,
    output logic [Count_width-1:0] Wr_count,
    output logic [1:0]             Dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_B  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    localparam logic [Count_width-1:0] CNT_ONE = {{(Count_width-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [2*Data_width-1:0] hold;
    logic                    last;
    logic                    grant0;
    logic                    grant1;

    // Tie-break: round-robin against the last winner, or Req1 always in priority mode.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (bus.Req0_Valid && bus.Req1_Valid) begin
                if (Prio_mode || !last) grant1 = 1'b1;
                else                    grant0 = 1'b1;
            end else if (bus.Req0_Valid) begin
                grant0 = 1'b1;
            end else if (bus.Req1_Valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign bus.Req0_Ready = grant0;
    assign bus.Req1_Ready = grant1;
    assign bus.Winc       = (state != IDLE) && !bus.Wfull;
    assign Busy           = (state != IDLE);
    assign Dbg_state      = state;

    always_comb begin
        case (state)
            WR_B, WR_LO: bus.Wrdata = hold[Data_width-1:0];
            WR_HI:       bus.Wrdata = hold[2*Data_width-1:Data_width];
            default:     bus.Wrdata = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            hold     <= '0;
            last     <= 1'b1;
            Wr_count <= '0;
        end else begin
            if (bus.Winc) Wr_count <= Wr_count + CNT_ONE;
            case (state)
                IDLE: begin
                    if (grant0) begin
                        hold  <= {{Data_width{1'b0}}, bus.Req0_Data};
                        last  <= 1'b0;
                        state <= WR_B;
                    end else if (grant1) begin
                        hold  <= bus.Req1_Data;
                        last  <= 1'b1;
                        state <= WR_LO;
                    end
                end
                // Advance only on an issued write, so Wfull stalls hold state and data.
                WR_B:    if (bus.Winc) state <= IDLE;
                WR_LO:   if (bus.Winc) state <= WR_HI;
                WR_HI:   if (bus.Winc) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: hand-computed per-cycle expectations and a write scoreboard.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          Rclk_tb = 1'b0;
    logic          rst_tb;
    logic          prio_mode;
    logic          busy;
    logic [CW-1:0] wr_count;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    int full_writes = 0;
    int dual_ready = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [10:0]   tbl3[10];
    logic [10:0]   tbl4[6];

    fifo_wr_arbiter_if #(.Data_width(DW)) bus ();

    fifo_wr_arbiter #(.Data_width(DW), .Count_width(CW)) dut (
        .Clk       (Rclk_tb),
        .Rst       (rst_tb),
        .Prio_mode (prio_mode),
        .bus       (bus),
        .Busy      (busy),
        .Wr_count  (wr_count),
        .Dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 Rclk_tb = ~Rclk_tb;

    // Write monitor: inputs are stable from negedge to the following posedge.
    always @(negedge Rclk_tb) begin
        if (rst_tb && bus.Winc) got_q.push_back(bus.Wrdata);
        if (bus.Winc && bus.Wfull) full_writes++;
        if (bus.Req0_Ready && bus.Req1_Ready) dual_ready++;
    end

    task automatic tick();
        @(posedge Rclk_tb);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare logged FIFO writes against the expected queue, then clear both.
    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cycle(input string tag, input logic [10:0] e);
        #1;
        chk({tag, "_r0"},   bus.Req0_Ready, e[10]);
        chk({tag, "_r1"},   bus.Req1_Ready, e[9]);
        chk({tag, "_winc"}, bus.Winc,       e[8]);
        chk({tag, "_wdat"}, bus.Wrdata,     e[7:0]);
    endtask

    initial begin
        tbl3 = '{{3'b100, 8'h00}, {3'b001, 8'hA0}, {3'b010, 8'h00}, {3'b001, 8'h34}, {3'b001, 8'h12},
                 {3'b100, 8'h00}, {3'b001, 8'hA0}, {3'b010, 8'h00}, {3'b001, 8'h34}, {3'b001, 8'h12}};
        tbl4 = '{{3'b010, 8'h00}, {3'b001, 8'h88}, {3'b001, 8'h77},
                 {3'b010, 8'h00}, {3'b001, 8'h88}, {3'b001, 8'h77}};

        rst_tb         = 1'b0;
        prio_mode      = 1'b0;
        bus.Req0_Valid = 1'b0;
        bus.Req0_Data  = '0;
        bus.Req1_Valid = 1'b0;
        bus.Req1_Data  = '0;
        bus.Wfull      = 1'b0;
        tick();
        tick();

        // Reset state
        chk_cycle("rst", {3'b000, 8'h00});
        chk("rst_busy",  busy,      1'b0);
        chk("rst_count", wr_count,  16'd0);
        chk("rst_state", dbg_state, 2'd0);
        rst_tb = 1'b1;
        tick();

        // Req0 only: 0x11 then 0x12
        bus.Req0_Valid = 1'b1;
        bus.Req0_Data  = 8'h11;
        chk_cycle("b_c1", {3'b100, 8'h00});
        tick();
        bus.Req0_Data = 8'h12;
        chk_cycle("b_c2", {3'b001, 8'h11});
        chk("b_c2_busy", busy, 1'b1);
        tick();
        chk_cycle("b_c3", {3'b100, 8'h00});
        tick();
        bus.Req0_Valid = 1'b0;
        chk_cycle("b_c4", {3'b001, 8'h12});
        tick();
        chk("b_busy",  busy,     1'b0);
        chk("b_count", wr_count, 16'd2);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        check_writes("b");

        // Req1 only: 0xBEEF, low byte first
        bus.Req1_Valid = 1'b1;
        bus.Req1_Data  = 16'hBEEF;
        chk_cycle("w_c1", {3'b010, 8'h00});
        tick();
        bus.Req1_Valid = 1'b0;
        chk_cycle("w_c2", {3'b001, 8'hEF});
        tick();
        chk_cycle("w_c3", {3'b001, 8'hBE});
        chk("w_c3_state", dbg_state, 2'd3);
        tick();
        chk("w_count", wr_count, 16'd4);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        check_writes("w");

        // Both valid, round-robin: last winner was Req1, so Req0 takes the first tie
        bus.Req0_Valid = 1'b1;
        bus.Req0_Data  = 8'hA0;
        bus.Req1_Valid = 1'b1;
        bus.Req1_Data  = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            chk_cycle($sformatf("rr_c%0d", c), tbl3[c]);
            tick();
        end
        bus.Req0_Valid = 1'b0;
        bus.Req1_Valid = 1'b0;
        chk("rr_count", wr_count, 16'd10);
        exp_q = '{8'hA0, 8'h34, 8'h12, 8'hA0, 8'h34, 8'h12};
        check_writes("rr");

        // Both valid, fixed priority: Req1 wins every grant
        prio_mode      = 1'b1;
        bus.Req0_Valid = 1'b1;
        bus.Req1_Valid = 1'b1;
        bus.Req1_Data  = 16'h7788;
        for (int c = 0; c < 6; c++) begin
            chk_cycle($sformatf("pr_c%0d", c), tbl4[c]);
            tick();
        end
        bus.Req0_Valid = 1'b0;
        bus.Req1_Valid = 1'b0;
        prio_mode      = 1'b0;
        chk("pr_count", wr_count, 16'd14);
        exp_q = '{8'h88, 8'h77, 8'h88, 8'h77};
        check_writes("pr");

        // FIFO fills after the low byte: high byte stalls in WR_HI, Req0 stays blocked
        bus.Req1_Valid = 1'b1;
        bus.Req1_Data  = 16'h5566;
        chk_cycle("f_c1", {3'b010, 8'h00});
        tick();
        bus.Req1_Valid = 1'b0;
        chk_cycle("f_c2", {3'b001, 8'h66});
        tick();
        bus.Wfull      = 1'b1;
        bus.Req0_Valid = 1'b1;
        bus.Req0_Data  = 8'h99;
        chk_cycle("f_c3", {3'b000, 8'h55});
        chk("f_c3_busy", busy, 1'b1);
        tick();
        chk_cycle("f_c4", {3'b000, 8'h55});
        chk("f_c4_state", dbg_state, 2'd3);
        tick();
        bus.Wfull = 1'b0;
        chk_cycle("f_c5", {3'b001, 8'h55});
        tick();
        chk_cycle("f_c6", {3'b100, 8'h00});
        tick();
        bus.Req0_Valid = 1'b0;
        chk_cycle("f_c7", {3'b001, 8'h99});
        tick();
        chk("f_count", wr_count, 16'd17);
        exp_q = '{8'h66, 8'h55, 8'h99};
        check_writes("f");

        // Asynchronous reset in WR_LO discards the word, then Req0 works normally
        bus.Req1_Valid = 1'b1;
        bus.Req1_Data  = 16'hCAFE;
        tick();
        bus.Req1_Valid = 1'b0;
        #1;
        chk("r_pre_state", dbg_state, 2'd2);
        rst_tb = 1'b0;
        chk_cycle("r_async", {3'b000, 8'h00});
        chk("r_busy",  busy,      1'b0);
        chk("r_count", wr_count,  16'd0);
        chk("r_state", dbg_state, 2'd0);
        tick();
        rst_tb = 1'b1;
        tick();
        bus.Req0_Valid = 1'b1;
        bus.Req0_Data  = 8'h42;
        chk_cycle("r_c1", {3'b100, 8'h00});
        tick();
        bus.Req0_Valid = 1'b0;
        chk_cycle("r_c2", {3'b001, 8'h42});
        tick();
        chk("r_count_after", wr_count, 16'd1);
        exp_q.push_back(8'h42);
        check_writes("r");

        chk("no_write_while_full", full_writes, 0);
        chk("never_dual_ready",    dual_ready,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
